// File: rtl/mem_rd_arbiter.sv
// Round-robin arbiter/sequencer for the shared wait-state memory read port.
// Optional DLY-timeout abort is enabled by defining MEM_RD_ARB_TIMEOUT_EN.
module mem_rd_arbiter #(
    parameter int N_REQ    = 4,
    parameter int ADDR_W   = 8,
    parameter int MAX_WAIT = 15
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [N_REQ-1:0]          req,
    input  logic [N_REQ*ADDR_W-1:0]   req_addr,
    output logic [N_REQ-1:0]          gnt,
    output logic [N_REQ-1:0]          ds,
    output logic                      mem_rd,
    output logic [ADDR_W-1:0]         mem_addr,
    input  logic                      mem_ws,
    output logic                      timeout_err
);

    localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    // Three-bit encoding leaves spare codes so an upset state recovers to IDLE.
    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_READ = 3'd1,
        S_DLY  = 3'd2,
        S_DONE = 3'd3
    } state_t;

    if (N_REQ < 2 || N_REQ > 8 || MAX_WAIT < 2) begin : g_param_check
        $error("mem_rd_arbiter: unsupported N_REQ/MAX_WAIT");
    end

    state_t              state_q, state_d;
    logic [N_REQ-1:0]    gnt_q, gnt_d;
    logic [N_REQ-1:0]    ds_q, ds_d;
    logic                mem_rd_q, mem_rd_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [PTR_W-1:0]    rr_ptr_q, rr_ptr_d;
    logic [PTR_W-1:0]    win_q, win_d;

    logic [ADDR_W-1:0]   addr_arr [N_REQ];
    logic                win_found;
    logic [PTR_W-1:0]    win_idx;
    logic [N_REQ-1:0]    win_onehot;
    logic [PTR_W-1:0]    rr_next;

`ifdef MEM_RD_ARB_TIMEOUT_EN
    localparam int WC_W = $clog2(MAX_WAIT + 1);
    localparam logic [WC_W-1:0] WAIT_LAST = WC_W'(MAX_WAIT - 1);
    localparam logic [WC_W-1:0] WAIT_MAX  = WC_W'(MAX_WAIT);
    logic [WC_W-1:0]     wait_cnt_q, wait_cnt_d;
    logic                timeout_err_q, timeout_err_d;
`endif

    genvar gi;
    generate
        for (gi = 0; gi < N_REQ; gi++) begin : g_addr_unpack
            assign addr_arr[gi] = req_addr[gi*ADDR_W +: ADDR_W];
        end
    endgenerate

    // First requester at or above rr_ptr, wrapping modulo N_REQ.
    always_comb begin
        int j;
        win_found = 1'b0;
        win_idx   = '0;
        j         = 0;
        for (int k = 0; k < N_REQ; k++) begin
            j = int'(rr_ptr_q) + k;
            if (j >= N_REQ) begin
                j = j - N_REQ;
            end
            if (!win_found && req[PTR_W'(j)]) begin
                win_found = 1'b1;
                win_idx   = PTR_W'(j);
            end
        end
    end

    always_comb begin
        win_onehot          = '0;
        win_onehot[win_idx] = 1'b1;
    end

    assign rr_next = (win_q == PTR_W'(N_REQ - 1)) ? '0 : win_q + 1'b1;

    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        ds_d       = '0;
        mem_rd_d   = 1'b0;
        mem_addr_d = mem_addr_q;
        rr_ptr_d   = rr_ptr_q;
        win_d      = win_q;
`ifdef MEM_RD_ARB_TIMEOUT_EN
        wait_cnt_d    = wait_cnt_q;
        timeout_err_d = 1'b0;
`endif
        case (state_q)
            S_IDLE: begin
                gnt_d      = '0;
                mem_addr_d = '0;
                if (win_found) begin
                    state_d    = S_READ;
                    gnt_d      = win_onehot;
                    mem_addr_d = addr_arr[win_idx];
                    mem_rd_d   = 1'b1;
                    win_d      = win_idx;
                end
            end
            S_READ: begin
                state_d  = S_DLY;
                mem_rd_d = 1'b1;
            end
            S_DLY: begin
                if (mem_ws) begin
`ifdef MEM_RD_ARB_TIMEOUT_EN
                    if (wait_cnt_q != WAIT_MAX) begin
                        wait_cnt_d = wait_cnt_q + 1'b1;
                    end
                    if (wait_cnt_q == WAIT_LAST) begin
                        state_d       = S_DONE;
                        ds_d          = gnt_q;
                        timeout_err_d = 1'b1;
                    end else begin
                        state_d  = S_READ;
                        mem_rd_d = 1'b1;
                    end
`else
                    state_d  = S_READ;
                    mem_rd_d = 1'b1;
`endif
                end else begin
                    state_d = S_DONE;
                    ds_d    = gnt_q;
                end
            end
            S_DONE: begin
                state_d    = S_IDLE;
                gnt_d      = '0;
                mem_addr_d = '0;
                rr_ptr_d   = rr_next;
`ifdef MEM_RD_ARB_TIMEOUT_EN
                wait_cnt_d = '0;
`endif
            end
            default: begin
                state_d    = S_IDLE;
                gnt_d      = '0;
                mem_addr_d = '0;
`ifdef MEM_RD_ARB_TIMEOUT_EN
                wait_cnt_d = '0;
`endif
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            gnt_q      <= '0;
            ds_q       <= '0;
            mem_rd_q   <= 1'b0;
            mem_addr_q <= '0;
            rr_ptr_q   <= '0;
            win_q      <= '0;
`ifdef MEM_RD_ARB_TIMEOUT_EN
            wait_cnt_q    <= '0;
            timeout_err_q <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            ds_q       <= ds_d;
            mem_rd_q   <= mem_rd_d;
            mem_addr_q <= mem_addr_d;
            rr_ptr_q   <= rr_ptr_d;
            win_q      <= win_d;
`ifdef MEM_RD_ARB_TIMEOUT_EN
            wait_cnt_q    <= wait_cnt_d;
            timeout_err_q <= timeout_err_d;
`endif
        end
    end

    assign gnt      = gnt_q;
    assign ds       = ds_q;
    assign mem_rd   = mem_rd_q;
    assign mem_addr = mem_addr_q;
`ifdef MEM_RD_ARB_TIMEOUT_EN
    assign timeout_err = timeout_err_q;
`else
    assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_mem_rd_arbiter.sv
// Directed scoreboard bench for mem_rd_arbiter (build with or without
// MEM_RD_ARB_TIMEOUT_EN to select the wait-timeout scenario).
module tb_mem_rd_arbiter;

    localparam int N_REQ    = 4;
    localparam int ADDR_W   = 8;
    localparam int MAX_WAIT = 15;

    logic                    clk;
    logic                    rst;
    logic [N_REQ-1:0]        req;
    logic [N_REQ*ADDR_W-1:0] req_addr;
    logic [N_REQ-1:0]        gnt;
    logic [N_REQ-1:0]        ds;
    logic                    mem_rd;
    logic [ADDR_W-1:0]       mem_addr;
    logic                    mem_ws;
    logic                    timeout_err;

    typedef struct {
        logic [N_REQ-1:0]  g;
        logic [ADDR_W-1:0] a;
        logic              t;
    } exp_t;

    exp_t sb[$];
    int   n_vec;
    int   n_err;

    mem_rd_arbiter #(
        .N_REQ    (N_REQ),
        .ADDR_W   (ADDR_W),
        .MAX_WAIT (MAX_WAIT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .req_addr    (req_addr),
        .gnt         (gnt),
        .ds          (ds),
        .mem_rd      (mem_rd),
        .mem_addr    (mem_addr),
        .mem_ws      (mem_ws),
        .timeout_err (timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [ADDR_W-1:0] addr_of(input int w);
        return ADDR_W'(8'hA1 + 8'h13 * w);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
        n_vec++;
        assert (obs === want) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input int w, input logic t);
        exp_t e;
        e.g = N_REQ'(1) << w;
        e.a = addr_of(w);
        e.t = t;
        sb.push_back(e);
    endtask

    // Completion monitor: pops the expected transaction on each ds strobe.
    always @(negedge clk) begin
        if (!rst && ds !== '0) begin
            if (sb.size() == 0) begin
                check("ds_unexpected", 32'(ds), 32'h0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("sb_ds", 32'(ds), 32'(e.g));
                check("sb_gnt", 32'(gnt), 32'(e.g));
                check("sb_addr", 32'(mem_addr), 32'(e.a));
                check("sb_terr", 32'(timeout_err), 32'(e.t));
                $display("txn done: ds=%b addr=%h terr=%b", ds, mem_addr, timeout_err);
            end
        end else if (!rst && timeout_err !== 1'b0) begin
            check("terr_without_ds", 32'(timeout_err), 32'h0);
        end
    end

    // One full transaction starting from IDLE; ends back in IDLE.
    task automatic do_txn(input logic [N_REQ-1:0] r, input int w, input int nws,
                          input logic [N_REQ-1:0] r_after, input bit poke_addr);
        logic [N_REQ-1:0] oh;
        int rd;
        oh = N_REQ'(1) << w;
        push_exp(w, 1'b0);
        req    = r;
        mem_ws = 1'b0;
        tick();
        check("gnt_read", 32'(gnt), 32'(oh));
        check("mem_rd_read", 32'(mem_rd), 32'h1);
        check("mem_addr_read", 32'(mem_addr), 32'(addr_of(w)));
        check("ds_read", 32'(ds), 32'h0);
        req = r_after;
        if (poke_addr) req_addr[w*ADDR_W +: ADDR_W] = 8'hEE;
        rd = 1;
        for (int v = 0; v <= nws; v++) begin
            mem_ws = (v < nws);
            tick();
            if (mem_rd) rd++;
            tick();
            if (mem_rd) rd++;
        end
        mem_ws = 1'b0;
        check("ds_done", 32'(ds), 32'(oh));
        check("gnt_done", 32'(gnt), 32'(oh));
        check("mem_rd_done", 32'(mem_rd), 32'h0);
        check("rd_cycles", 32'(rd), 32'(2 * (nws + 1)));
        tick();
        check("idle_after", 32'({gnt, ds, mem_rd, mem_addr}), 32'h0);
        if (poke_addr) req_addr[w*ADDR_W +: ADDR_W] = addr_of(w);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        int rd;
        bit saw_ds;
        n_vec  = 0;
        n_err  = 0;
        rst    = 1'b1;
        req    = '0;
        mem_ws = 1'b0;
        for (int i = 0; i < N_REQ; i++) req_addr[i*ADDR_W +: ADDR_W] = addr_of(i);
        repeat (3) @(posedge clk);
        #1;
        check("rst_gnt", 32'(gnt), 32'h0);
        check("rst_ds", 32'(ds), 32'h0);
        check("rst_mem_rd", 32'(mem_rd), 32'h0);
        check("rst_mem_addr", 32'(mem_addr), 32'h0);
        check("rst_terr", 32'(timeout_err), 32'h0);
        rst = 1'b0;

        // Advance rr_ptr, then reset in the middle of a DLY with gnt=0010.
        do_txn(4'b0001, 0, 0, 4'b0001, 1'b0);
        req = 4'b0010;
        tick();
        check("mid_gnt", 32'(gnt), 32'h2);
        req = '0;
        tick();
        check("mid_dly_rd", 32'(mem_rd), 32'h1);
        #2 rst = 1'b1;
        #1;
        check("async_rst_outs", 32'({gnt, ds, mem_rd, mem_addr, timeout_err}), 32'h0);
        #2 rst = 1'b0;
        do_txn(4'b0011, 0, 0, 4'b0011, 1'b0);

        // Single requester, no wait states.
        do_txn(4'b0100, 2, 0, 4'b0100, 1'b0);
        do_txn(4'b1000, 3, 0, 4'b1000, 1'b0);

        // All clients requesting: strict rotation.
        for (int k = 0; k < 5; k++) do_txn(4'b1111, k % 4, 0, 4'b1111, 1'b0);

        // Three wait-state DLY visits stretch mem_rd to 8 cycles.
        do_txn(4'b0100, 2, 3, 4'b0100, 1'b0);

        // Client drops req and changes its address after the grant.
        do_txn(4'b0010, 1, 0, 4'b0000, 1'b1);

        // Memory stuck in wait state.
        req    = 4'b0001;
        mem_ws = 1'b1;
`ifdef MEM_RD_ARB_TIMEOUT_EN
        push_exp(0, 1'b1);
        tick();
        req = '0;
        rd  = 0;
        n   = 0;
        while (ds === '0 && n < 200) begin
            if (mem_rd) rd++;
            tick();
            n++;
        end
        check("to_bounded", 32'(n < 200), 32'h1);
        check("to_rd_cycles", 32'(rd), 32'(2 * MAX_WAIT));
        check("to_ds", 32'(ds), 32'h1);
        check("to_terr", 32'(timeout_err), 32'h1);
        mem_ws = 1'b0;
        tick();
        check("to_idle", 32'({gnt, ds, mem_rd, timeout_err}), 32'h0);
        do_txn(4'b0001, 0, 2, 4'b0000, 1'b0);
`else
        push_exp(0, 1'b0);
        tick();
        req    = '0;
        saw_ds = 1'b0;
        repeat (100) begin
            tick();
            if (ds !== '0) saw_ds = 1'b1;
        end
        check("stuck_busy_rd", 32'(mem_rd), 32'h1);
        check("stuck_gnt", 32'(gnt), 32'h1);
        check("stuck_no_ds", 32'(saw_ds), 32'h0);
        mem_ws = 1'b0;
        n = 0;
        while (ds === '0 && n < 4) begin
            tick();
            n++;
        end
        check("stuck_release_ds", 32'(ds), 32'h1);
        check("stuck_terr", 32'(timeout_err), 32'h0);
        tick();
        check("stuck_idle", 32'({gnt, ds, mem_rd}), 32'h0);
`endif

        tick();
        check("sb_empty", 32'(sb.size()), 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
